// File: rtl/mealy_seq_detector_param.sv
// Parametrised Mealy serial-pattern detector with KMP fallback,
// run-time overlap select and a saturating match counter.
module mealy_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int SW = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    // Longest proper prefix of PATTERN that is a suffix of
    // (first k pattern bits followed by b).
    function automatic int kmp(input int k, input logic b);
        logic s [PAT_LEN];
        int   len;
        int   res;
        logic ok;
        for (int i = 0; i < PAT_LEN; i++)
            s[i] = (i < k) ? PATTERN[PAT_LEN-1-i] : b;
        len = k + 1;
        res = 0;
        for (int j = 1; j < PAT_LEN; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_LEN; i++)
                    if (i < j && PATTERN[PAT_LEN-1-i] != s[len-j+i])
                        ok = 1'b0;
                if (ok)
                    res = j;
            end
        end
        return res;
    endfunction

    logic [SW-1:0]      nxt0 [PAT_LEN];
    logic [SW-1:0]      nxt1 [PAT_LEN];
    logic [PAT_LEN-1:0] expv;

    for (genvar g = 0; g < PAT_LEN; g++) begin : g_tbl
        assign nxt0[g] = SW'(kmp(g, 1'b0));
        assign nxt1[g] = SW'(kmp(g, 1'b1));
        assign expv[g] = PATTERN[PAT_LEN-1-g];
    end

    logic [SW-1:0] k;
    logic [SW-1:0] k_nxt;
    logic          hit;

    assign hit = x_valid && !reset && (x == expv[k]);
    assign y   = hit && (k == LAST);

    always_comb begin
        k_nxt = k;
        if (x_valid) begin
            if (y && !overlap)
                k_nxt = '0;
            else if (hit && k != LAST)
                k_nxt = k + SW'(1);
            else
                k_nxt = x ? nxt1[k] : nxt0[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k           <= '0;
            y_q         <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            k   <= k_nxt;
            y_q <= y;
            if (count_clr) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (y && match_count != CMAX) begin
                match_count <= match_count + CNT_W'(1);
                if (match_count == CMAX - CNT_W'(1))
                    count_sat <= 1'b1;
            end
        end
    end

endmodule
